stage1_feeder: RTL and testbench
================================

# stage1_feeder

Stream-side driver for the 9-lane convolution stage: it sequences weight/BN-config loading, then streams feature-map columns into the stage's 9-lane input. It inserts zero bubbles when upstream stalls and tags every column with a validity bit delayed to match the stage latency, so downstream logic knows which stage output columns are real. It sits between the on-chip feature/weight buffers and the stage input. The stage itself has no back-pressure or valid signalling; this block supplies them.

## Interface
Parameters:
- INT_BITS, 13, word width of every lane
- LATENCY, 28, cycles from a column on st_in to its column on the stage ReLU output; must equal the instantiated stage's latency

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a job; honoured only while busy=0
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at job end
- w_valid  in  1  weight/BN beat valid
- w_ready  out  1  high only in LOAD
- w_data  in  9*INT_BITS  one weight row, lane 0 in LSBs
- bn_data  in  2*INT_BITS  BN config pair accompanying the w_data beat
- fm_valid  in  1  feature column valid
- fm_ready  out  1  high only in STREAM
- fm_data  in  9*INT_BITS  one feature column, lane 0 in LSBs
- fm_last  in  1  marks the final feature column
- st_weight_en  out  1  stage weight/BN shift enable
- st_in  out  9*INT_BITS  stage lane inputs
- st_bn_config  out  2*INT_BITS  stage BN config input
- res_valid  out  1  stage output column this cycle is real
- res_last  out  1  stage output column this cycle is the last real one

## Operation
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE: all stage outputs zero. start=1 -> LOAD; the beat counter clears.
- LOAD: w_ready=1. An accepted beat (w_valid=1) drives st_weight_en=1, st_in=w_data, st_bn_config=bn_data on the next cycle.
  - A non-accepted cycle drives st_weight_en=0 with zero data. The stage array and BN chain shift only on st_weight_en=1, so gaps are harmless.
  - After the 9th accepted beat -> STREAM.
- STREAM: fm_ready=1, st_weight_en=0, st_bn_config=0.
  - An accepted column drives st_in=fm_data next cycle and pushes valid=1 (last=fm_last) into the delay line.
  - fm_valid=0 drives a zero column and pushes valid=0, last=0.
  - Accepted fm_last -> DRAIN.
- DRAIN: st_in zero, delay-line pushes 0. A counter runs until res_last has been emitted, then done=1 for one cycle -> IDLE.
- Delay line: LATENCY-deep 2-bit shift register (valid, last) advancing every cycle in every state. res_valid/res_last are its output.
- start while busy is ignored. fm_last on the first column is legal; the job has one real column.
- Word contents are passed through unmodified; no arithmetic.

## Timing
- Reset (reset=0 at a clk edge): state=IDLE; busy, done, w_ready, fm_ready, st_weight_en, res_valid, res_last all 0; st_in, st_bn_config all 0; delay line and counters cleared.
- Reset mid-job: the same values apply from the next edge. No res_valid is ever produced for columns accepted before the reset.
- start accepted at edge T: busy=1 and w_ready=1 from T+1.
- Input to stage latency: 1 cycle; all stage-facing outputs are registered.
- A column on st_in at cycle C produces res_valid at cycle C+LATENCY.
- The last column on st_in at cycle L produces res_last at L+LATENCY. done=1 and busy=0 at L+LATENCY+1; start is accepted from that cycle on.
- Handshakes: transfer when valid&ready on the same edge. ready never depends combinationally on valid.

## Structure
- Package stage_pkg: LANES=9, BN_WORDS=2, W_BEATS=9, state enum (IDLE, LOAD, STREAM, DRAIN), default LATENCY.
- One sub-module, valid_delay_line: a parameterised-depth, parameterised-width shift register with synchronous active-low clear. It is also reused by downstream blocks.

## Test plan
- Reset/idle: hold reset=0 for 3 cycles, then release without start -> all outputs 0, busy=0 for 50 cycles.
- Clean job: load 9 beats back-to-back (w_data lane k = beat*9+k), then 4 columns with fm_last on column 4 -> st_weight_en high exactly 9 cycles; res_valid high at cycles C+28 for the 4 columns; res_last on the 4th; done one cycle later.
- Stalls: w_valid toggles 1,0,1 during LOAD and fm_valid has a 3-cycle gap after column 2 -> exactly 9 weight_en cycles; 3 zero columns with res_valid=0 at the matching output slots.
- Single column: fm_last on the first column -> one res_valid cycle, with res_last=1 in that same cycle.
- Reset mid-STREAM after 2 columns -> IDLE next cycle; no res_valid over the following LATENCY+5 cycles; a new start works normally.
- start asserted in LOAD, STREAM and DRAIN -> no effect; the beat count and done timing are unchanged.

Source files
------------

// File: rtl/stage1_feeder_pkg.sv
// Shared constants and types for the 9-lane convolution stage feeder.
// Imported by the feeder, its stream interface and the bench.
package stage_pkg;

    localparam int LANES        = 9;
    localparam int BN_WORDS     = 2;
    localparam int W_BEATS      = 9;
    localparam int DEF_INT_BITS = 13;
    localparam int DEF_LATENCY  = 28;
    localparam int BEAT_CNT_W   = $clog2(W_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // True while the beat counter points at the final weight row of a job.
    function automatic logic final_beat(input logic [BEAT_CNT_W-1:0] cnt);
        return cnt == BEAT_CNT_W'(W_BEATS - 1);
    endfunction

endpackage

// File: rtl/stage1_feeder_if.sv
// Weight/feature input streams plus stage-facing and result-tag signals.
// The master modport is the feeder, the slave side is buffers/stage/downstream.
interface stage1_feeder_if #(
    parameter int INT_BITS = 13
);
    import stage_pkg::*;

    logic                         w_valid;
    logic                         w_ready;
    logic [LANES*INT_BITS-1:0]    w_data;
    logic [BN_WORDS*INT_BITS-1:0] bn_data;

    logic                         fm_valid;
    logic                         fm_ready;
    logic [LANES*INT_BITS-1:0]    fm_data;
    logic                         fm_last;

    logic                         st_weight_en;
    logic [LANES*INT_BITS-1:0]    st_in;
    logic [BN_WORDS*INT_BITS-1:0] st_bn_config;

    logic                         res_valid;
    logic                         res_last;

    modport master (
        input  w_valid, w_data, bn_data,
        input  fm_valid, fm_data, fm_last,
        output w_ready, fm_ready,
        output st_weight_en, st_in, st_bn_config,
        output res_valid, res_last
    );

    modport slave (
        output w_valid, w_data, bn_data,
        output fm_valid, fm_data, fm_last,
        input  w_ready, fm_ready,
        input  st_weight_en, st_in, st_bn_config,
        input  res_valid, res_last
    );

endinterface

// File: rtl/stage1_feeder_valid_delay_line.sv
// Fixed-depth shift register for per-column tag bits, cleared synchronously.
// Advances every cycle; shared with downstream blocks that need aligned tags.
module valid_delay_line #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/stage1_feeder.sv
// Sequences weight/BN loading, then streams feature columns into the stage,
// padding stalls with zero columns and tagging columns to match stage latency.
module stage1_feeder
    import stage_pkg::*;
#(
    parameter int INT_BITS = DEF_INT_BITS,
    parameter int LATENCY  = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    stage1_feeder_if.master   bus
);

    localparam int DATA_W = LANES * INT_BITS;
    localparam int BN_W   = BN_WORDS * INT_BITS;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    state_e                  state_q;
    logic [BEAT_CNT_W-1:0]   beat_q;
    logic [CNT_W-1:0]        drain_q;
    logic                    done_q;
    logic                    wen_q;
    logic [DATA_W-1:0]       st_in_q;
    logic [BN_W-1:0]         bn_q;
    logic                    col_vld_q;
    logic                    col_last_q;
    logic [1:0]              tag_dly;

    logic w_acc;
    logic fm_acc;

    // Ready depends only on state, so acceptance never loops through valid.
    assign bus.w_ready  = (state_q == LOAD);
    assign bus.fm_ready = (state_q == STREAM);
    assign w_acc        = bus.w_valid  && (state_q == LOAD);
    assign fm_acc       = bus.fm_valid && (state_q == STREAM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            wen_q      <= 1'b0;
            st_in_q    <= '0;
            bn_q       <= '0;
            col_vld_q  <= 1'b0;
            col_last_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            wen_q      <= w_acc;
            bn_q       <= w_acc ? bus.bn_data : '0;
            col_vld_q  <= fm_acc;
            col_last_q <= fm_acc && bus.fm_last;
            if (w_acc) begin
                st_in_q <= bus.w_data;
            end else if (fm_acc) begin
                st_in_q <= bus.fm_data;
            end else begin
                st_in_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        beat_q  <= '0;
                    end
                end
                LOAD: begin
                    if (w_acc) begin
                        beat_q <= beat_q + BEAT_CNT_W'(1);
                        if (final_beat(beat_q)) begin
                            state_q <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (fm_acc && bus.fm_last) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    // drain_q reaches LATENCY in the cycle res_last is on the output.
                    if (drain_q == CNT_W'(LATENCY)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        drain_q <= drain_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (LATENCY),
        .WIDTH (2)
    ) u_tag_dly (
        .clk    (clk),
        .reset  (reset),
        .din_i  ({col_last_q, col_vld_q}),
        .dout_o (tag_dly)
    );

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign bus.st_weight_en = wen_q;
    assign bus.st_in        = st_in_q;
    assign bus.st_bn_config = bn_q;
    assign bus.res_valid    = tag_dly[0];
    assign bus.res_last     = tag_dly[1];

endmodule

// File: tb/tb_stage1_feeder.sv
// Directed bench for stage1_feeder: job table plus reset corner sequences.
module tb_stage1_feeder;
    import stage_pkg::*;

    localparam int IB  = 13;
    localparam int LAT = 28;
    localparam int DW  = LANES * IB;
    localparam int BW  = BN_WORDS * IB;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    stage1_feeder_if #(.INT_BITS(IB)) bus();

    stage1_feeder #(.INT_BITS(IB), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] wpat;
        int          wlen;
        logic [15:0] fpat;
        int          flen;
        bit          hold;
        int          exp_done;
        int          exp_last;
        int          exp_first;
        int          ncol;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [DW-1:0] beat_word(input int b);
        logic [DW-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*IB +: IB] = IB'(b * 9 + k);
        return w;
    endfunction

    function automatic logic [DW-1:0] col_word(input int j);
        logic [DW-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*IB +: IB] = IB'(1000 + j * 9 + k);
        return w;
    endfunction

    function automatic logic [BW-1:0] bn_word(input int b);
        return {IB'(b + 200), IB'(b + 100)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-job monitor, indexed by cycles since the start-accept edge.
    bit           mon_en = 1'b0;
    int           s_edge = 0;
    int           wen_cnt, wen_first, data_err, nz_cnt, col_seen;
    int           res_last_rel, done_rel, done_cnt, busy_cnt, wr_cnt, fr_cnt;
    logic [127:0] res_map;

    always @(negedge clk) begin
        if (!mon_en) begin
            wen_cnt <= 0; wen_first <= -1; data_err <= 0; nz_cnt <= 0; col_seen <= 0;
            res_last_rel <= -1; done_rel <= -1; done_cnt <= 0; busy_cnt <= 0;
            wr_cnt <= 0; fr_cnt <= 0; res_map <= '0;
        end else begin
            if (bus.st_weight_en === 1'b1) begin
                if (wen_cnt == 0) wen_first <= cyc - s_edge;
                if (bus.st_in !== beat_word(wen_cnt) || bus.st_bn_config !== bn_word(wen_cnt))
                    data_err <= data_err + 1;
                wen_cnt <= wen_cnt + 1;
            end else begin
                if (bus.st_bn_config !== '0) data_err <= data_err + 1;
                else if (bus.st_in !== '0) begin
                    if (bus.st_in !== col_word(col_seen)) data_err <= data_err + 1;
                    col_seen <= col_seen + 1;
                end
            end
            if (bus.st_in !== '0) nz_cnt <= nz_cnt + 1;
            if (bus.res_valid === 1'b1 && (cyc - s_edge) < 128) res_map[7'(cyc - s_edge)] <= 1'b1;
            if (bus.res_last === 1'b1) res_last_rel <= cyc - s_edge;
            if (done === 1'b1) begin
                done_rel <= cyc - s_edge;
                done_cnt <= done_cnt + 1;
            end
            if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
            if (bus.w_ready === 1'b1) wr_cnt <= wr_cnt + 1;
            if (bus.fm_ready === 1'b1) fr_cnt <= fr_cnt + 1;
        end
    end

    task automatic run_job(input vec_t v);
        int b;
        int c;
        b = 0;
        c = 0;
        start = 1'b1;
        step();
        s_edge = cyc;
        mon_en = 1'b1;
        if (!v.hold) start = 1'b0;
        for (int i = 0; i < v.wlen; i++) begin
            bus.w_valid = v.wpat[i];
            if (v.wpat[i]) begin
                bus.w_data  = beat_word(b);
                bus.bn_data = bn_word(b);
                b++;
            end else begin
                bus.w_data  = '1;
                bus.bn_data = '1;
            end
            step();
        end
        bus.w_valid = 1'b0; bus.w_data = '0; bus.bn_data = '0;
        for (int j = 0; j < v.flen; j++) begin
            bus.fm_valid = v.fpat[j];
            if (v.fpat[j]) begin
                bus.fm_data = col_word(c);
                bus.fm_last = (j == v.flen - 1);
                c++;
            end else begin
                bus.fm_data = '1;
                bus.fm_last = 1'b1;
            end
            step();
        end
        bus.fm_valid = 1'b0; bus.fm_last = 1'b0; bus.fm_data = '0;
        while (cyc - s_edge < 72) begin
            if (cyc - s_edge >= 33) start = 1'b0;
            step();
        end
        mon_en = 1'b0;
        start  = 1'b0;
        chk({v.name, " wen_cnt"},   128'(wen_cnt),      128'(W_BEATS));
        chk({v.name, " wen_first"}, 128'(wen_first),    128'(1));
        chk({v.name, " data"},      128'(data_err),     128'(0));
        chk({v.name, " nz_cols"},   128'(nz_cnt),       128'(W_BEATS + v.ncol));
        chk({v.name, " res_map"},   res_map,            128'(v.fpat) << v.exp_first);
        chk({v.name, " res_last"},  128'(res_last_rel), 128'(v.exp_last));
        chk({v.name, " done_at"},   128'(done_rel),     128'(v.exp_done));
        chk({v.name, " done_cnt"},  128'(done_cnt),     128'(1));
        chk({v.name, " busy_cnt"},  128'(busy_cnt),     128'(v.exp_done));
        chk({v.name, " w_ready"},   128'(wr_cnt),       128'(v.wlen));
        chk({v.name, " fm_ready"},  128'(fr_cnt),       128'(v.flen));
    endtask

    function automatic logic [8:0] outs();
        return {busy, done, bus.w_ready, bus.fm_ready, bus.st_weight_en,
                bus.res_valid, bus.res_last, |bus.st_in, |bus.st_bn_config};
    endfunction

    initial begin
        int quiet;
        vecs[0] = '{"clean",     16'h01FF,  9, 16'h000F, 4, 1'b0, 42, 41, 38, 4};
        vecs[1] = '{"stall",     16'h03FD, 10, 16'h0063, 7, 1'b0, 46, 45, 39, 4};
        vecs[2] = '{"single",    16'h01FF,  9, 16'h0001, 1, 1'b0, 39, 38, 38, 1};
        vecs[3] = '{"busystart", 16'h01FF,  9, 16'h000F, 4, 1'b1, 42, 41, 38, 4};

        reset = 1'b0; start = 1'b0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.bn_data = '0;
        bus.fm_valid = 1'b0; bus.fm_data = '0; bus.fm_last = 1'b0;

        for (int i = 0; i < 3; i++) step();
        chk("reset outs", 128'(outs()), 128'(0));
        reset = 1'b1;
        quiet = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (outs() !== 9'b0) quiet++;
        end
        chk("idle quiet", 128'(quiet), 128'(0));

        for (int i = 0; i < 4; i++) run_job(vecs[i]);

        // Reset two columns into STREAM, then confirm no stale tags and a clean restart.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < W_BEATS; b++) begin
            bus.w_valid = 1'b1; bus.w_data = beat_word(b); bus.bn_data = bn_word(b);
            step();
        end
        bus.w_valid = 1'b0; bus.w_data = '0; bus.bn_data = '0;
        for (int j = 0; j < 2; j++) begin
            bus.fm_valid = 1'b1; bus.fm_data = col_word(j); bus.fm_last = 1'b0;
            step();
        end
        chk("pre-reset busy", 128'(busy), 128'(1));
        reset = 1'b0; bus.fm_valid = 1'b0; bus.fm_data = '0;
        step();
        chk("mid reset outs", 128'(outs()), 128'(0));
        reset = 1'b1;
        quiet = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            step();
            if (bus.res_valid !== 1'b0 || bus.res_last !== 1'b0) quiet++;
        end
        chk("post reset res", 128'(quiet), 128'(0));
        run_job(vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
